// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pkg                                                                 |
// | Shared memory-map defaults and boot loader state encoding.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mips_pkg;

    localparam int c_addr_w    = 9;
    localparam int c_mem_bytes = 512;

    localparam logic [2:0] c_st_load  = 3'd0;
    localparam logic [2:0] c_st_write = 3'd1;
    localparam logic [2:0] c_st_hold  = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_err   = 3'd4;

    typedef enum logic [2:0] {
        S_LOAD  = c_st_load,
        S_WRITE = c_st_write,
        S_HOLD  = c_st_hold,
        S_RUN   = c_st_run,
        S_ERR   = c_st_err
    } state_t;

endpackage
`default_nettype wire

// File: rtl/boot_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | boot_loader_if                                                           |
// | Byte stream input, RAM MOV/MOC write port and CPU release status.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface boot_loader_if #(
    parameter int ADDR_W = mips_pkg::c_addr_w
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_mov;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_moc;
    logic              cpu_clear;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   byte_count;

    modport master (
        input  in_valid, in_data, in_last, mem_moc,
        output in_ready, mem_mov, mem_addr, mem_din,
               cpu_clear, load_done, load_err, byte_count
    );

    modport slave (
        output in_valid, in_data, in_last, mem_moc,
        input  in_ready, mem_mov, mem_addr, mem_din,
               cpu_clear, load_done, load_err, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/boot_loader_moc_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moc_watchdog                                                             |
// | Counts write cycles without MOC and flags the cycle the limit is hit.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module moc_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  wire clk,
    input  wire rst,
    input  wire i_start,
    input  wire i_active,
    input  wire i_moc,
    output wire o_expire
);
    localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_active && !i_moc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the edge that would bring the count to TIMEOUT.
    assign o_expire = i_active & ~i_moc & (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | boot_loader                                                              |
// | Streams an image into RAM over MOV/MOC, then releases the CPU reset.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w,
    parameter int MEM_BYTES   = c_mem_bytes,
    parameter int MOC_TIMEOUT = 15,
    parameter int CLEAR_HOLD  = 2
) (
    input  wire           Clk,
    input  wire           Clear,
    boot_loader_if.master bus
);
    localparam int                  c_hold_w   = $clog2(CLEAR_HOLD + 1);
    localparam logic [ADDR_W-1:0]   c_addr_top = ADDR_W'(MEM_BYTES - 1);
    localparam logic [c_hold_w-1:0] c_hold_end = c_hold_w'(CLEAR_HOLD - 1);

    state_t              r_state;
    logic                r_in_ready;
    logic                r_mem_mov;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_din;
    logic                r_last_q;
    logic                r_cpu_clear;
    logic                r_load_done;
    logic                r_load_err;
    logic [ADDR_W:0]     r_byte_count;
    logic [c_hold_w-1:0] r_hold_cnt;

    wire w_accept = (r_state == S_LOAD) && r_in_ready && bus.in_valid;
    wire w_write  = (r_state == S_WRITE);
    wire w_expire;

    moc_watchdog #(
        .TIMEOUT (MOC_TIMEOUT)
    ) u_watchdog (
        .clk      (Clk),
        .rst      (Clear),
        .i_start  (w_accept),
        .i_active (w_write),
        .i_moc    (bus.mem_moc),
        .o_expire (w_expire)
    );

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state      <= S_LOAD;
            r_in_ready   <= 1'b0;
            r_mem_mov    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_last_q     <= 1'b0;
            r_cpu_clear  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_byte_count <= '0;
            r_hold_cnt   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_mem_din  <= bus.in_data;
                        r_last_q   <= bus.in_last;
                        r_mem_mov  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_WRITE;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_moc) begin
                        r_mem_mov    <= 1'b0;
                        r_byte_count <= r_byte_count + 1'b1;
                        r_hold_cnt   <= '0;
                        if (r_mem_addr != c_addr_top) begin
                            r_mem_addr <= r_mem_addr + 1'b1;
                        end
                        // A full RAM without in_last is an overflow, but the image is still run.
                        if (r_last_q) begin
                            r_state <= S_HOLD;
                        end else if (r_mem_addr == c_addr_top) begin
                            r_load_err <= 1'b1;
                            r_state    <= S_HOLD;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end else if (w_expire) begin
                        r_load_err <= 1'b1;
                        r_mem_mov  <= 1'b0;
                        r_state    <= S_ERR;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == c_hold_end) begin
                        r_cpu_clear <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_RUN, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.mem_mov    = r_mem_mov;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.cpu_clear  = r_cpu_clear;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;
    assign bus.byte_count = r_byte_count;

endmodule
`default_nettype wire
